// File: rtl/uart_wb_cmd_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_wb_cmd_gen_if
//  Brief    : Request/response and UART byte-stream bundle for uart_wb_cmd_gen.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_wb_cmd_gen_if;
  logic        cmd_req;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_ack;
  logic [31:0] cmd_rdata;
  logic        cmd_err;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  // master is the command generator; slave is the requester plus UART core side
  modport master (
    input  cmd_req, cmd_we, cmd_addr, cmd_wdata, tx_ready, rx_data, rx_valid,
    output cmd_ack, cmd_rdata, cmd_err, busy, tx_data, tx_valid
  );

  modport slave (
    output cmd_req, cmd_we, cmd_addr, cmd_wdata, tx_ready, rx_data, rx_valid,
    input  cmd_ack, cmd_rdata, cmd_err, busy, tx_data, tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/uart_wb_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_wb_cmd_gen
//  Brief    : Turns register read/write requests into ASCII "wm"/"rm" UART
//             commands and parses the hex read response into a 32-bit word.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_wb_cmd_gen #(
  parameter logic [15:0] RESP_TIMEOUT = 16'd50000
) (
  input  logic              mclk,
  input  logic              reset_n,
  uart_wb_cmd_gen_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX      = 3'd1,
    S_RX_WAIT = 3'd2,
    S_RX_DATA = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [7:0] c_ch_w    = 8'h77;
  localparam logic [7:0] c_ch_r    = 8'h72;
  localparam logic [7:0] c_ch_m    = 8'h6D;
  localparam logic [7:0] c_ch_sp   = 8'h20;
  localparam logic [7:0] c_ch_cr   = 8'h0D;
  localparam logic [7:0] c_ch_lf   = 8'h0A;
  localparam logic [4:0] c_wr_last = 5'd20;
  localparam logic [4:0] c_rd_last = 5'd11;

  function automatic logic [7:0] f_hex_char(input logic [3:0] n);
    f_hex_char = (n < 4'd10) ? {4'h3, n} : {4'h4, n - 4'd9};
  endfunction

  // {valid, nibble}; letters of either case land on 0x?1..0x?6
  function automatic logic [4:0] f_hex_val(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39)
      f_hex_val = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      f_hex_val = {1'b1, b[3:0] + 4'd9};
    else
      f_hex_val = 5'd0;
  endfunction

  state_t      r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_idx;
  logic [31:0] r_shift;
  logic [3:0]  r_ncnt;
  logic [15:0] r_tmo;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_busy;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;

  logic [3:0]  w_anib;
  logic [3:0]  w_dnib;
  logic [7:0]  w_byte;
  logic [4:0]  w_rx_hex;
  logic        w_rx_ws;
  logic        w_tmo_exp;

  always_comb begin
    w_anib = 4'(r_addr  >> {5'd10 - r_idx, 2'b00});
    w_dnib = 4'(r_wdata >> {5'd19 - r_idx, 2'b00});
    w_byte = c_ch_lf;
    case (r_idx)
      5'd0:    w_byte = r_we ? c_ch_w : c_ch_r;
      5'd1:    w_byte = c_ch_m;
      5'd2:    w_byte = c_ch_sp;
      5'd11:   w_byte = r_we ? c_ch_sp : c_ch_lf;
      default: begin
        if (r_idx >= 5'd3 && r_idx <= 5'd10)
          w_byte = f_hex_char(w_anib);
        else if (r_idx >= 5'd12 && r_idx <= 5'd19)
          w_byte = f_hex_char(w_dnib);
      end
    endcase
  end

  assign w_rx_hex  = f_hex_val(bus.rx_data);
  assign w_rx_ws   = (bus.rx_data == c_ch_sp) || (bus.rx_data == c_ch_cr) ||
                     (bus.rx_data == c_ch_lf);
  assign w_tmo_exp = (r_tmo == RESP_TIMEOUT - 16'd1);

  // cmd_ack/cmd_err are set on the transition into DONE so they are high
  // exactly during the single DONE cycle.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_idx      <= 5'd0;
      r_shift    <= 32'd0;
      r_ncnt     <= 4'd0;
      r_tmo      <= 16'd0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 32'd0;
      r_busy     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_req) begin
            r_we       <= bus.cmd_we;
            r_addr     <= bus.cmd_addr;
            r_wdata    <= bus.cmd_wdata;
            r_idx      <= 5'd0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= bus.cmd_we ? c_ch_w : c_ch_r;
            r_busy     <= 1'b1;
            r_state    <= S_TX;
          end
        end
        S_TX: begin
          if (r_tx_valid) begin
            if (bus.tx_ready) begin
              r_tx_valid <= 1'b0;
              if (r_idx == (r_we ? c_wr_last : c_rd_last)) begin
                if (r_we) begin
                  r_ack   <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_tmo   <= 16'd0;
                  r_state <= S_RX_WAIT;
                end
              end else begin
                r_idx <= r_idx + 5'd1;
              end
            end
          end else begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_byte;
          end
        end
        S_RX_WAIT: begin
          if (bus.rx_valid) begin
            r_tmo <= 16'd0;
            if (w_rx_hex[4]) begin
              r_shift <= {28'd0, w_rx_hex[3:0]};
              r_ncnt  <= 4'd1;
              r_state <= S_RX_DATA;
            end else if (!w_rx_ws) begin
              r_ack   <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (w_tmo_exp) begin
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        S_RX_DATA: begin
          if (bus.rx_valid) begin
            r_tmo <= 16'd0;
            if (w_rx_hex[4] && r_ncnt != 4'd8) begin
              r_shift <= {r_shift[27:0], w_rx_hex[3:0]};
              r_ncnt  <= r_ncnt + 4'd1;
            end else if (bus.rx_data == c_ch_lf && r_ncnt == 4'd8) begin
              r_ack   <= 1'b1;
              r_rdata <= r_shift;
              r_state <= S_DONE;
            end else begin
              r_ack   <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (w_tmo_exp) begin
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ack   = r_ack;
  assign bus.cmd_err   = r_err;
  assign bus.cmd_rdata = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_wb_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_wb_cmd_gen
//  Brief    : Self-checking bench: table of requests, byte/result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_wb_cmd_gen;

  localparam int T = 100;
  localparam int K_NONE = 0, K_MIXED = 1, K_PLAIN = 2, K_BADCH = 3,
                 K_SHORT = 4, K_SILENT = 5, K_LONG = 6, K_JUNK = 7;
  localparam int NV = 12;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          kind;
    logic [31:0] rval;
    int          rdy;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  uart_wb_cmd_gen_if bus();

  uart_wb_cmd_gen #(.RESP_TIMEOUT(16'(T))) dut (
    .mclk    (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_tx[$];
  res_t       exp_res[$];
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  int         rx_term;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         hs_count = 0;
  int         last_hs_cyc = 0;
  int         ack_cyc = -1;
  int         rdy_pct = 100;
  string      hx = "0123456789ABCDEF";
  vec_t       vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus.tx_ready = (int'($urandom_range(0, 99)) < rdy_pct);
  end

  // Byte monitor: every handshake pops the expected byte; stalls must hold.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (prev_stall) begin
          chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
          chk("tx_hold_data", 32'(bus.tx_data), 32'(prev_data));
        end
        if (bus.tx_valid && bus.tx_ready) begin
          hs_count++;
          last_hs_cyc = cyc;
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_byte: got 0x%0h, expected no byte", bus.tx_data);
          end else begin
            chk("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
          end
        end
      end
      prev_stall = reset_n && bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input bit we, input logic [31:0] a, input logic [31:0] d);
    exp_tx.push_back(we ? 8'h77 : 8'h72);
    exp_tx.push_back(8'h6D);
    exp_tx.push_back(8'h20);
    for (int i = 7; i >= 0; i--) exp_tx.push_back(hx[a[i*4 +: 4]]);
    if (we) begin
      exp_tx.push_back(8'h20);
      for (int i = 7; i >= 0; i--) exp_tx.push_back(hx[d[i*4 +: 4]]);
    end
    exp_tx.push_back(8'h0A);
  endtask

  task automatic build_resp(input int kind, input logic [31:0] v);
    logic [7:0] c;
    rx_q.delete();
    rx_term = -1;
    case (kind)
      K_MIXED: begin
        rx_q.push_back(8'h0D);
        rx_q.push_back(8'h0A);
        for (int i = 0; i < 8; i++) begin
          c = hx[v[(7-i)*4 +: 4]];
          if (i % 2 == 1 && c >= 8'h41) c = c + 8'h20;
          rx_q.push_back(c);
        end
        rx_q.push_back(8'h0A);
        rx_term = 10;
      end
      K_PLAIN, K_BADCH, K_LONG: begin
        if (kind == K_PLAIN) rx_q.push_back(8'h20);
        for (int i = 0; i < 8; i++)
          rx_q.push_back((kind == K_BADCH && i == 4) ? 8'h47 : hx[v[(7-i)*4 +: 4]]);
        if (kind == K_LONG) rx_q.push_back(hx[5]);
        rx_q.push_back(8'h0A);
        rx_term = (kind == K_PLAIN) ? 9 : (kind == K_BADCH) ? 4 : 8;
      end
      K_SHORT, K_JUNK: begin
        if (kind == K_JUNK) rx_q.push_back(8'h58);
        for (int i = 0; i < 4; i++) rx_q.push_back(hx[v[(7-i)*4 +: 4]]);
        rx_q.push_back(8'h0A);
        rx_term = (kind == K_JUNK) ? 0 : 4;
      end
      default: ;
    endcase
  endtask

  task automatic run(input vec_t v, input string tag);
    res_t r;
    rdy_pct = v.rdy;
    push_frame(v.we, v.addr, v.wdata);
    r.err   = v.exp_err;
    r.rdata = v.exp_rdata;
    exp_res.push_back(r);
    build_resp(v.kind, v.rval);
    rx_cyc.delete();
    ack_cyc = -1;
    @(negedge clk);
    bus.cmd_req   = 1'b1;
    bus.cmd_we    = v.we;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    fork
      begin : ack_wait
        int   n;
        res_t e;
        @(negedge clk);
        chk({tag, "_busy_on_capture"}, 32'(bus.busy), 32'd1);
        chk({tag, "_txv_on_capture"}, 32'(bus.tx_valid), 32'd1);
        n = 0;
        while (!bus.cmd_ack && n < 4000) begin
          @(negedge clk);
          n++;
        end
        bus.cmd_req = 1'b0;
        if (!bus.cmd_ack || exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_ack: got no cmd_ack in %0d cycles, expected one", tag, n);
          if (exp_res.size() != 0) void'(exp_res.pop_front());
        end else begin
          ack_cyc = cyc;
          e = exp_res.pop_front();
          chk({tag, "_err"}, 32'(bus.cmd_err), 32'(e.err));
          chk({tag, "_rdata"}, bus.cmd_rdata, e.rdata);
        end
        @(negedge clk);
        chk({tag, "_ack_pulse"}, 32'(bus.cmd_ack), 32'd0);
        chk({tag, "_busy_release"}, 32'(bus.busy), 32'd0);
      end
      begin : responder
        int n;
        if (rx_q.size() != 0) begin
          n = 0;
          while (exp_tx.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
          end
          foreach (rx_q[i]) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bus.rx_data  = rx_q[i];
            bus.rx_valid = 1'b1;
            rx_cyc.push_back(cyc);
            @(negedge clk);
            bus.rx_valid = 1'b0;
          end
        end
      end
    join
    chk({tag, "_frame_drained"}, 32'(exp_tx.size()), 32'd0);
    exp_tx.delete();
    if (ack_cyc >= 0) begin
      if (v.we)
        chk({tag, "_write_latency"}, 32'(ack_cyc - last_hs_cyc), 32'd1);
      else if (v.kind == K_SILENT)
        chk({tag, "_timeout_cycles"}, 32'(ack_cyc - last_hs_cyc - 1), 32'(T));
      else if (rx_term >= 0 && rx_term < rx_cyc.size())
        chk({tag, "_read_latency"}, 32'(ack_cyc - rx_cyc[rx_term]), 32'd1);
    end
  endtask

  initial begin
    int n;
    int base;
    bit ack_seen;
    vec_t wv;

    vt[0]  = '{1'b1, 32'h3002_0024, 32'h1122_3344, K_NONE,   32'h0,          100, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h3002_0028, 32'h0,         K_MIXED,  32'h2233_4ABC,  100, 1'b0, 32'h2233_4ABC};
    vt[2]  = '{1'b1, 32'h3002_0024, 32'h1122_3344, K_NONE,   32'h0,           30, 1'b0, 32'h2233_4ABC};
    vt[3]  = '{1'b0, 32'h0000_0004, 32'h0,         K_SILENT, 32'h0,          100, 1'b1, 32'h2233_4ABC};
    vt[4]  = '{1'b0, 32'h0000_0010, 32'h0,         K_BADCH,  32'h1234_5678,   60, 1'b1, 32'h2233_4ABC};
    vt[5]  = '{1'b0, 32'h0000_0014, 32'h0,         K_PLAIN,  32'hDEAD_BEEF,  100, 1'b0, 32'hDEAD_BEEF};
    vt[6]  = '{1'b0, 32'h0000_0018, 32'h0,         K_SHORT,  32'h1234_0000,  100, 1'b1, 32'hDEAD_BEEF};
    vt[7]  = '{1'b0, 32'h0000_001C, 32'h0,         K_PLAIN,  32'hDEAD_BEEF,  100, 1'b0, 32'hDEAD_BEEF};
    vt[8]  = '{1'b0, 32'hFFFF_FFF0, 32'h0,         K_LONG,   32'h89AB_CDEF,  100, 1'b1, 32'hDEAD_BEEF};
    vt[9]  = '{1'b0, 32'h0000_0020, 32'h0,         K_JUNK,   32'h0,          100, 1'b1, 32'hDEAD_BEEF};
    vt[10] = '{1'b0, 32'hA5A5_5A5A, 32'h0,         K_MIXED,  32'hFEDC_BA98,   30, 1'b0, 32'hFEDC_BA98};
    vt[11] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, K_NONE,   32'h0,           30, 1'b0, 32'hFEDC_BA98};

    bus.cmd_req   = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.rx_data   = 8'd0;
    bus.rx_valid  = 1'b0;
    bus.tx_ready  = 1'b1;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ack", 32'(bus.cmd_ack), 32'd0);
    chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    chk("rst_cmd_rdata", bus.cmd_rdata, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run(vt[i], $sformatf("v%0d", i));

    // Reset in the middle of a write frame, after the 7th byte is accepted.
    rdy_pct = 100;
    push_frame(1'b1, 32'hA0B1_C2D3, 32'h0F1E_2D3C);
    base = hs_count;
    @(negedge clk);
    bus.cmd_req   = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = 32'hA0B1_C2D3;
    bus.cmd_wdata = 32'h0F1E_2D3C;
    n = 0;
    while (hs_count < base + 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reset_bytes_sent", 32'(hs_count - base), 32'd7);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid_reset_tx_data", 32'(bus.tx_data), 32'd0);
    chk("mid_reset_busy", 32'(bus.busy), 32'd0);
    chk("mid_reset_rdata", bus.cmd_rdata, 32'd0);
    chk("mid_reset_err", 32'(bus.cmd_err), 32'd0);
    bus.cmd_req = 1'b0;
    exp_tx.delete();
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.cmd_ack) ack_seen = 1'b1;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.cmd_ack) ack_seen = 1'b1;
    end
    chk("mid_reset_no_ack", 32'(ack_seen), 32'd0);
    chk("mid_reset_not_resumed", 32'(bus.tx_valid | bus.busy), 32'd0);

    wv = '{1'b1, 32'h3002_0024, 32'h1122_3344, K_NONE, 32'h0, 100, 1'b0, 32'h0};
    run(wv, "post_reset_write");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
